// File: rtl/aes_iter_cipher_if.sv
// Block/key/ciphertext handshake bundle for the iterative AES engine.
// Bit 0 of in/key/out is the MSB of byte 0.
interface aes_iter_cipher_if #(parameter int Nk = 4);
  logic              in_valid;
  logic              in_ready;
  logic              key_new;
  logic [0:127]      in;
  logic [0:Nk*32-1]  key;
  logic              out_valid;
  logic              out_ready;
  logic [0:127]      out;

  modport slave  (input in_valid, key_new, in, key, out_ready,
                  output in_ready, out_valid, out);
  modport master (output in_valid, key_new, in, key, out_ready,
                  input in_ready, out_valid, out);
endinterface

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryptor: one round per clock, key schedule expanded one word
// per clock into a cached round-key file reused while key_new stays low.
module aes_iter_cipher #(
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst,
  aes_iter_cipher_if.slave bus
);
  localparam int Nr = Nk + 6;
  localparam int NW = 4 * (Nr + 1);

  generate
    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
      $error("aes_iter_cipher: Nk must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  state_t         state, nxt;
  logic [127:0]   st, out_q;
  logic [31:0]    w [NW];
  logic           sched_valid;
  logic [3:0]     rnd;
  logic [5:0]     wcnt;
  logic [2:0]     kidx;
  logic [7:0]     rcon;

  logic           accept, eff_new;
  logic [127:0]   sb, sr, mc, rk, rnd_out, key0;
  logic [31:0]    prev, tmp, new_w;
  logic [5:0]     rb;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign eff_new = bus.key_new || !sched_valid;
  assign key0    = bus.key[0:127];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;

  // Round datapath; byte n of the state sits at st[127-8n -: 8], column-major
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int n = 0; n < 16; n++) sb[127-8*n -: 8] = sbox(st[127-8*n -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    rb      = {rnd, 2'b00};
    rk      = {w[rb], w[rb+6'd1], w[rb+6'd2], w[rb+6'd3]};
    rnd_out = ((rnd == 4'(Nr)) ? sr : mc) ^ rk;
  end

  always_comb begin
    prev = w[wcnt - 6'd1];
    if (kidx == 3'd0)
      tmp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    else if (Nk == 8 && kidx == 3'd4)
      tmp = sub_word(prev);
    else
      tmp = prev;
    new_w = w[wcnt - 6'(Nk)] ^ tmp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = eff_new ? EXPAND : ROUND;
      EXPAND:  if (wcnt == 6'(NW-1)) nxt = ROUND;
      ROUND:   if (rnd == 4'(Nr)) nxt = DONE;
      DONE:    if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= '0;
      out_q       <= '0;
      sched_valid <= 1'b0;
      rnd         <= '0;
      wcnt        <= '0;
      kidx        <= '0;
      rcon        <= 8'h01;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (eff_new) begin
            st          <= bus.in ^ key0;
            sched_valid <= 1'b0;
            wcnt        <= 6'(Nk);
            kidx        <= '0;
            rcon        <= 8'h01;
          end else begin
            st  <= bus.in ^ {w[0], w[1], w[2], w[3]};
            rnd <= 4'd1;
          end
        end
        EXPAND: begin
          wcnt <= wcnt + 6'd1;
          kidx <= (kidx == 3'(Nk-1)) ? 3'd0 : kidx + 3'd1;
          if (kidx == 3'd0) rcon <= xt(rcon);
          if (wcnt == 6'(NW-1)) begin
            sched_valid <= 1'b1;
            rnd         <= 4'd1;
          end
        end
        ROUND: begin
          st  <= rnd_out;
          rnd <= rnd + 4'd1;
          if (rnd == 4'(Nr)) out_q <= rnd_out;
        end
        default: ;
      endcase
    end
  end

  // Round-key file carries no reset; sched_valid alone says whether it is usable
  always_ff @(posedge clk) begin
    if (accept && eff_new)
      for (int j = 0; j < Nk; j++) w[j] <= bus.key[32*j +: 32];
    else if (state == EXPAND)
      w[wcnt] <= new_w;
  end
endmodule
